result_packer: RTL
==================

Name: result_packer

Overview:
- Sits between the engine's 16-bit result write port and the 32-bit result FIFO that feeds the host block-throttled output pipe.
- Packs pairs of fp16 results into 32-bit words, low half first.
- On flush, emits any half-filled word, then pads the stream to a whole BLOCK_SIZE-word block. The host pipe releases only full blocks, so the last block of a layer never strands in the FIFO.

Parameters:
- DATA_W, 16, engine result width; OUT_W = 2*DATA_W.
- BLOCK_SIZE, 128, host transfer block in 32-bit words; must be a power of two.
- PAD_WORD, 32'h0000_0000, value written for pad words and the empty upper half of a partial word.
- CNT_W, 16, width of the total-words counter.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, synchronous active-low reset.
- in_valid, in, 1, engine result beat valid.
- in_data, in, DATA_W, engine result (fp16).
- in_ready, out, 1, packer can accept a beat this cycle.
- flush, in, 1, single-cycle pulse at end of operation (from csb when engine_ready rises).
- fifo_afull, in, 1, result FIFO almost full; at least 2 free words remain when this is low.
- out_data, out, 2*DATA_W, packed word to the result FIFO.
- out_we, out, 1, result FIFO write enable; registered.
- total_words, out, CNT_W, words written since reset, pad and checksum words included; saturates at all-ones.
- busy, out, 1, high in any state other than IDLE.
- done, out, 1, one-cycle pulse when flush handling completes.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; half_pending=0; blk_cnt=0; total_words=0.
  - out_we=0; out_data=0; done=0; busy=0; in_ready=0 during the reset cycle.
  - Reset mid-operation discards any pending half and any remaining pad with no FIFO write.
- States:
  - IDLE: waiting for first beat or flush.
  - PACK: accumulating beats.
  - TAIL: emit pending half-word.
  - CSUM: checksum word, only with the feature enabled.
  - PAD: write pad words.
  - DONE: one cycle, then back to IDLE.
- in_ready = (state is IDLE or PACK) && !fifo_afull. A beat is accepted when in_valid && in_ready.
- Packing:
  - First accepted beat latches into the low half; half_pending=1.
  - Second beat drives out_data={in_data, low}, with out_we=1 on the next cycle; half_pending=0.
  - Latency from second beat to out_we is 1 cycle.
- blk_cnt is log2(BLOCK_SIZE) bits. It increments on every out_we and wraps from BLOCK_SIZE-1 to 0.
- Flush:
  - Sampled in IDLE/PACK. A beat accepted in the same cycle as flush is processed before the flush takes effect.
  - Sequence: TAIL if half_pending (writes {PAD_WORD[31:16], low}) -> CSUM (if enabled) -> PAD while blk_cnt != 0 -> DONE.
  - If blk_cnt==0 and nothing is pending, go directly to DONE; no writes occur.
  - Flush outside IDLE/PACK is ignored.
- Backpressure: out_we is asserted only in cycles where fifo_afull was low at the decision edge. TAIL, CSUM and PAD stall while fifo_afull=1.
- At most one out_we per cycle. done pulses exactly once per accepted flush.

Optional Feature:
- Macro: RESULT_PACKER_CHECKSUM_EN.
- With the macro defined:
  - A 32-bit running XOR is kept over every data word written, including the TAIL word.
  - On flush, one checksum word is written after TAIL and before PAD, and counts toward blk_cnt.
  - The running XOR clears at DONE and at reset.
- Without it: no CSUM state and no checksum logic; padding follows TAIL directly.

Decomposition:
- Shared package/header (alongside macros.vh):
  - BLOCK_SIZE, shared with the top-level throttle.
  - PAD_WORD.
  - State encoding localparams.
- One natural sub-module, block_pad_counter: the blk_cnt modulo counter plus its "pad remaining" logic. It is reusable for the input-side pipes.

Test Plan:
- 4 beats 0x3C00,0x4000,0x4200,0x4400 then flush:
  - Words 0x4000_3C00 and 0x4400_4200.
  - Then 126 pad words of 0.
  - done one cycle after the last pad; total_words=128.
- 3 beats 0x0001,0x0002,0x0003 then flush:
  - 0x0002_0001, then 0x0000_0003 from TAIL, then 126 pads; total_words=128.
- 256 beats then flush:
  - 128 data words; blk_cnt=0 at flush, so no pads.
  - done within 2 cycles of flush; total_words=128.
- fifo_afull held high 10 cycles during PAD:
  - No out_we and in_ready=0 during the stall; padding resumes and the total is still a 128 multiple.
- rst_n low mid-PAD after 40 pads:
  - All outputs return to reset values next edge; no further writes.
  - A new flush in IDLE with no data produces zero writes.
- With RESULT_PACKER_CHECKSUM_EN, beats 0x1111,0x2222,0x3333,0x4444 then flush:
  - Checksum word 0x6666_2222 (0x2222_1111 XOR 0x4444_3333) as word 3, then 125 pads.

Source files
------------

// File: rtl/result_packer_pkg.sv
// result_packer_pkg: shared widths, block size, pad word and FSM states (CSUM exists only with RESULT_PACKER_CHECKSUM_EN)
package result_packer_pkg;
  localparam int DATA_W = 16;
  localparam int OUT_W = 2 * DATA_W;
  localparam int CNT_W = 16;
  localparam int BLOCK_SIZE = 128;
  localparam logic [OUT_W-1:0] PAD_WORD = 32'h0000_0000;
  typedef enum logic [2:0] {
    IDLE,
    PACK,
    TAIL,
`ifdef RESULT_PACKER_CHECKSUM_EN
    CSUM,
`endif
    PAD,
    DONE
  } state_t;
endpackage

// File: rtl/result_packer_block_pad_counter.sv
// block_pad_counter: modulo-SIZE write counter; pad_needed means the block is still partial after this cycle's write
module block_pad_counter
  import result_packer_pkg::*;
#(
  parameter int SIZE = BLOCK_SIZE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  output logic pad_needed
);
  localparam int W = $clog2(SIZE);
  logic [W-1:0] cnt, cnt_nxt;
  assign cnt_nxt = cnt + W'(inc);
  assign pad_needed = cnt_nxt != '0;
  always_ff @(posedge clk) begin
    cnt <= !rst_n ? '0 : cnt_nxt;
  end
endmodule

// File: rtl/result_packer.sv
// result_packer: packs fp16 pairs into 32-bit words and pads to whole blocks on flush; RESULT_PACKER_CHECKSUM_EN adds a checksum word
module result_packer
  import result_packer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  input  logic              fifo_afull,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_we,
  output logic [CNT_W-1:0]  total_words,
  output logic              busy,
  output logic              done
);
  state_t state, state_nxt, after_data;
  logic half_pending, hp_nxt, accept, flush_we, we, pad_needed;
  logic [DATA_W-1:0] low;
  logic [OUT_W-1:0] data_word, word;
  assign in_ready = rst_n && (state == IDLE || state == PACK) && !fifo_afull;
  assign accept = in_valid && in_ready;
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign flush_we = !fifo_afull && !(state inside {IDLE, PACK, DONE});
  assign we = (accept && half_pending) || flush_we;
  assign hp_nxt = state == TAIL ? half_pending && fifo_afull : half_pending ^ accept;
  assign data_word = state == PAD ? PAD_WORD :
                     state == TAIL ? {PAD_WORD[OUT_W-1:DATA_W], low} : {in_data, low};
`ifdef RESULT_PACKER_CHECKSUM_EN
  logic [OUT_W-1:0] csum;
  assign after_data = CSUM;
  assign word = state == CSUM ? csum : data_word;
  always_ff @(posedge clk) begin
    if (!rst_n || state == DONE) csum <= '0;
    else if (we && (state == PACK || state == TAIL)) csum <= csum ^ word;
  end
`else
  assign after_data = pad_needed ? PAD : DONE;
  assign word = data_word;
`endif
  block_pad_counter #(.SIZE(BLOCK_SIZE)) u_blk (
    .clk(clk),
    .rst_n(rst_n),
    .inc(we),
    .pad_needed(pad_needed)
  );
  // a beat accepted alongside flush is already folded into hp_nxt and pad_needed
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, PACK: state_nxt = flush ? (hp_nxt ? TAIL : after_data) : accept ? PACK : state;
      DONE: state_nxt = IDLE;
      default: if (!fifo_afull) state_nxt = state == TAIL ? after_data : pad_needed ? PAD : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      half_pending <= 1'b0;
      low <= '0;
      out_we <= 1'b0;
      out_data <= '0;
      total_words <= '0;
    end else begin
      state <= state_nxt;
      half_pending <= hp_nxt;
      out_we <= we;
      if (accept && !half_pending) low <= in_data;
      if (we) out_data <= word;
      if (we && total_words != '1) total_words <= total_words + CNT_W'(1);
    end
  end
endmodule
